sram_write_arbiter: RTL

Single-clock round-robin arbiter that shares one SRAM write path between two write requesters, the image buffer writer and the overlay writer. Each requester presents 54-bit {mask,addr,data} write words over ready/valid. The block grants one requester at a time for bursts of up to `MaxBurst` words and forwards the winning words through a one-deep output register. The output feeds a single write port of the SRAM arbiter, which frees the second write port.

---
 rtl/sram_write_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sram_write_arbiter.sv
// Round-robin arbiter that merges two ready/valid SRAM write streams into one
// registered write port, granting bursts of up to MaxBurst words per owner.
module sram_write_arbiter #(
  parameter int unsigned MaxBurst = 16,
  parameter int unsigned Width    = 54
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             w0_din_valid,
  input  logic [Width-1:0] w0_din,
  output logic             w0_din_ready,
  input  logic             w1_din_valid,
  input  logic [Width-1:0] w1_din,
  output logic             w1_din_ready,
  output logic             dout_valid,
  output logic [Width-1:0] dout,
  input  logic             dout_ready,
  output logic [1:0]       grant,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_e;

  localparam logic [7:0] LastCnt = 8'(MaxBurst - 1);

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic               dout_valid_q, dout_valid_d;
  logic [Width-1:0]   dout_q, dout_d;

  logic               slot_free;
  logic               accept0, accept1;
  logic               own_valid, other_valid;
  state_e             other_state;
  logic               other_idx;

  assign slot_free    = ~dout_valid_q | dout_ready;
  assign w0_din_ready = (state_q == GRANT0) & slot_free;
  assign w1_din_ready = (state_q == GRANT1) & slot_free;
  assign accept0      = w0_din_valid & w0_din_ready;
  assign accept1      = w1_din_valid & w1_din_ready;

  // Owner-relative view so both grant states share one transition body.
  assign own_valid   = (state_q == GRANT1) ? w1_din_valid : w0_din_valid;
  assign other_valid = (state_q == GRANT1) ? w0_din_valid : w1_din_valid;
  assign other_state = (state_q == GRANT1) ? GRANT0 : GRANT1;
  assign other_idx   = (state_q == GRANT1) ? 1'b0 : 1'b1;

  // NOTE: every variable gets its hold value before any branch; a path that
  // leaves one unassigned would infer a latch instead of combinational logic.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    burst_cnt_d  = burst_cnt_q;
    dout_valid_d = dout_valid_q;
    dout_d       = dout_q;

    if (accept0) begin
      dout_d       = w0_din;
      dout_valid_d = 1'b1;
    end else if (accept1) begin
      dout_d       = w1_din;
      dout_valid_d = 1'b1;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // last_q = 1 means requester 0 is next in line on a tie.
        if (w0_din_valid && (!w1_din_valid || last_q)) begin
          state_d     = GRANT0;
          last_d      = 1'b0;
          burst_cnt_d = '0;
        end else if (w1_din_valid) begin
          state_d     = GRANT1;
          last_d      = 1'b1;
          burst_cnt_d = '0;
        end
      end
      GRANT0, GRANT1: begin
        if (!own_valid) begin
          if (other_valid) begin
            state_d     = other_state;
            last_d      = other_idx;
            burst_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (slot_free) begin
          if (burst_cnt_q == LastCnt) begin
            // Owner is still valid here, so without a rival it simply re-enters.
            burst_cnt_d = '0;
            if (other_valid) begin
              state_d = other_state;
              last_d  = other_idx;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      burst_cnt_q  <= '0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      burst_cnt_q  <= burst_cnt_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign grant      = {state_q == GRANT1, state_q == GRANT0};
  assign busy       = (state_q != IDLE) | dout_valid_q;

endmodule
